// File: rtl/pixel_fetch.sv
// Framebuffer fetch for a scaled image window: turns VGA hc/vc into framebuffer
// reads and delivers pixel color plus delayed sync/visible flags 3 cycles later.
module pixel_fetch #(
   parameter int          IMG_W      = 160,
   parameter int          IMG_H      = 120,
   parameter int          SCALE_LOG2 = 2,
   parameter logic [7:0]  BG_COLOR   = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] hc,
   input  logic [10:0] vc,
   input  logic        visible_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [15:0] fb_addr,
   output logic        fb_rd_en,
   input  logic [7:0]  fb_data,
   output logic [7:0]  color_out,
   output logic        visible_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        frame_start
);

   localparam int          WIN_W    = IMG_W << SCALE_LOG2;
   localparam int          WIN_H    = IMG_H << SCALE_LOG2;
   localparam logic [10:0] SUB_MASK = 11'((1 << SCALE_LOG2) - 1);

   logic        in_win;
   logic        line_start;
   logic        frame_top;
   logic        row_step;
   logic [15:0] row_base;
   logic [15:0] row_base_next;
   logic [15:0] column;
   logic [15:0] addr_calc;

   // pipeline flags: stage 1 (address issued), stage 2 (data returned by RAM)
   logic win1, vis1, hs1, vs1, fs1;
   logic win2, vis2, hs2, vs2, fs2;

   always_comb begin
      in_win     = visible_in && (32'(hc) < WIN_W) && (32'(vc) < WIN_H);
      line_start = (hc == '0);
      frame_top  = line_start && (vc == '0);
      row_step   = line_start && (vc != '0) && ((vc & SUB_MASK) == '0)
                   && (32'(vc) < WIN_H);
      column     = 16'(hc >> SCALE_LOG2);
   end

   // row_base_next equals row_base except at line start, so using it for the
   // address gives the same-cycle bypass of the hc==0 update for free.
   always_comb begin
      row_base_next = row_base;
      if (frame_top)
         row_base_next = '0;
      else if (row_step)
         row_base_next = row_base + 16'(IMG_W);
      addr_calc = row_base_next + column;
   end

   always_ff @(posedge clk) begin
      if (rst)
         row_base <= '0;
      else
         row_base <= row_base_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fb_addr  <= '0;
         fb_rd_en <= 1'b0;
         win1     <= 1'b0;
         vis1     <= 1'b0;
         hs1      <= 1'b0;
         vs1      <= 1'b0;
         fs1      <= 1'b0;
      end else begin
         if (in_win)
            fb_addr <= addr_calc;
         fb_rd_en <= in_win;
         win1     <= in_win;
         vis1     <= visible_in;
         hs1      <= hsync_in;
         vs1      <= vsync_in;
         fs1      <= frame_top && visible_in;
      end
   end

   // The RAM's registered output is the stage-2 capture; only the flags move here.
   always_ff @(posedge clk) begin
      if (rst) begin
         win2 <= 1'b0;
         vis2 <= 1'b0;
         hs2  <= 1'b0;
         vs2  <= 1'b0;
         fs2  <= 1'b0;
      end else begin
         win2 <= win1;
         vis2 <= vis1;
         hs2  <= hs1;
         vs2  <= vs1;
         fs2  <= fs1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         color_out   <= '0;
         visible_out <= 1'b0;
         hsync_out   <= 1'b0;
         vsync_out   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         if (!vis2)
            color_out <= '0;
         else if (win2)
            color_out <= fb_data;
         else
            color_out <= BG_COLOR;
         visible_out <= vis2;
         hsync_out   <= hs2;
         vsync_out   <= vs2;
         frame_start <= fs2;
      end
   end

endmodule
